hs_fifo_slice: RTL and testbench
================================

Name: hs_fifo_slice

Overview:
Parametrised valid/ready buffer that decouples a handshake producer from a handshake consumer.
It generalises the 8-bit single-register master/slave handshake to configurable data width and depth, and adds an optional fall-through mode, occupancy status and a synchronous flush.
It sits between any two handshake endpoints, including AXI4-Lite channel endpoints, and preserves order with no loss or duplication.

Parameters:
DATA_W, 8, payload width in bits
DEPTH, 4, storage entries; must be a power of two and >= 2
FALL_THROUGH, 0, 1 = an empty buffer forwards input to output in the same cycle
CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset; asynchronous, active-high
flush  in  1  synchronous clear of contents
s_valid  in  1  producer has data
s_data  in  DATA_W  producer payload
s_ready  out  1  buffer can accept
m_valid  out  1  buffer presents data
m_data  out  DATA_W  output payload
m_ready  in  1  consumer accepts
count  out  CNT_W  stored entries, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (async assert, sync release): count=0, pointers=0, m_valid=0, empty=1, full=0. s_ready is forced to 0 while rst is high. Storage contents are not reset; m_data is don't-care when m_valid=0.
- Write transfer: s_valid && s_ready at a rising edge. Read transfer: m_valid && m_ready at a rising edge.
- s_ready = !full && !flush && !rst. s_ready has no combinational path from m_ready, so there is no write-through when full.
- m_valid = !empty. If FALL_THROUGH=1 and the buffer is empty, m_valid = s_valid and m_data = s_data instead.
- Latency, FALL_THROUGH=0: a word written at edge N appears on m_valid/m_data after edge N. Minimum 1 cycle.
- Latency, FALL_THROUGH=1, empty: 0 cycles. A bypass transfer (empty, s_valid, m_ready) does not touch storage and count stays 0.
- Throughput: one transfer per cycle in each direction, sustained.
- Simultaneous write and read with 0<count<DEPTH: count unchanged, both pointers advance.
- Simultaneous write and read when empty with FALL_THROUGH=0: only the write happens (m_valid=0).
- Write pointer and read pointer wrap modulo DEPTH. Full and empty are derived from count, never from pointer equality.
- Output stability: while m_valid && !m_ready, m_valid and m_data are held unchanged.
- Producer obligation: s_data is held stable while s_valid && !s_ready. The bench checks this as an assertion.
- flush=1 at an edge: count, pointers → 0, and entries are discarded. A write or read in the same cycle is ignored; no transfer is counted.
- During the flush cycle: s_ready=0; m_valid=0 with FALL_THROUGH=0.
- Reset mid-operation: immediate clear as above; in-flight words are lost. The first transfer after release is the first word presented after release.
- count, full and empty are registered-state decodes, valid in the same cycle as the state.

Decomposition:
- Shared package hs_pkg holds:
  - a clog2 function (if the toolchain lacks $clog2)
  - default DATA_W and DEPTH constants used by the handshake blocks
  - a localparam for the counter width rule
- One sub-module, hs_fifo_mem: DEPTH x DATA_W register array, write port (we, waddr, wdata), asynchronous read port (raddr, rdata), no reset.
- Pointer, count and handshake control stay in hs_fifo_slice.

Test Plan:
- Reset and release, DEPTH=4: after release s_ready=1, m_valid=0, count=0, empty=1. Assert rst mid-stream with count=3 → m_valid=0 and count=0 immediately, with no clock edge.
- Fill to full with m_ready=0, writing 0x6B, 0x00, 0xCC, 0x11 → count 1, 2, 3, 4; full=1, s_ready=0. A fifth word 0x22 is held with s_valid=1 and is not accepted.
- Drain with m_ready=1 → m_data order 0x6B, 0x00, 0xCC, 0x11, one per cycle; then empty=1, m_valid=0.
- Streaming:
  - s_valid=m_ready=1 for 20 cycles with an incrementing pattern: output equals input delayed by 1 cycle (FALL_THROUGH=0) or 0 cycles (FALL_THROUGH=1), and count stays at 1 or 0 respectively.
  - Randomised m_ready and s_valid for 1000 cycles, DATA_W=32, DEPTH=8: the scoreboard finds no loss, no duplication, and order preserved across pointer wrap.
- Flush with count=3 and simultaneous s_valid=m_ready=1 → count=0, no transfer accepted, no data emitted. The next word 0xA5 is the first output.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared constants and sizing helpers for the valid/ready handshake blocks.
package hs_pkg;

    localparam int HS_DATA_W = 8;
    localparam int HS_DEPTH  = 4;

    function automatic int hs_clog2(input int value);
        int r;
        r = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 32'sd1;
            end
        end
        return r;
    endfunction

    // Occupancy must represent 0..DEPTH inclusive, hence one bit beyond the pointer width.
    function automatic int hs_cnt_w(input int depth);
        return hs_clog2(depth) + 32'sd1;
    endfunction

    localparam int HS_CNT_W = hs_cnt_w(HS_DEPTH);

endpackage

// File: rtl/hs_fifo_mem.sv
// DEPTH x DATA_W storage array with one write port and an asynchronous read port.
module hs_fifo_mem
    import hs_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W,
    parameter int DEPTH  = HS_DEPTH,
    parameter int ADDR_W = hs_clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write; contents intentionally carry no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/hs_fifo_slice.sv
// Parametrised valid/ready buffer with optional fall-through, occupancy status and flush.
module hs_fifo_slice
    import hs_pkg::*;
#(
    parameter int DATA_W       = HS_DATA_W,
    parameter int DEPTH        = HS_DEPTH,
    parameter bit FALL_THROUGH = 1'b0,
    parameter int CNT_W        = hs_cnt_w(DEPTH)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int               PTR_W    = hs_clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] rdata_s;
    logic              empty_s;
    logic              full_s;
    logic              bypass_s;
    logic              wr_fire_s;
    logic              rd_fire_s;
    logic              store_wr_s;
    logic              store_rd_s;

    assign empty_s  = (count_r == {CNT_W{1'b0}});
    assign full_s   = (count_r == CNT_FULL);
    assign bypass_s = FALL_THROUGH && empty_s;

    // Ready depends only on state, flush and reset, never on m_ready.
    assign s_ready = !full_s && !flush && !rst;
    assign m_valid = !flush && !rst && (bypass_s ? s_valid : !empty_s);
    assign m_data  = bypass_s ? s_data : rdata_s;

    assign wr_fire_s  = s_valid && s_ready;
    assign rd_fire_s  = m_valid && m_ready;
    // A bypass transfer moves the word straight through and leaves storage untouched.
    assign store_wr_s = wr_fire_s && !(bypass_s && rd_fire_s);
    assign store_rd_s = rd_fire_s && !empty_s;

    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

    // Pointer and occupancy update; flush discards everything and ignores same-cycle transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (store_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (store_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({store_wr_s, store_rd_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    hs_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (store_wr_s),
        .waddr (wr_ptr_r),
        .wdata (s_data),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

endmodule

// File: tb/tb_hs_fifo_slice.sv
// Scoreboard bench: instance A (8-bit, depth 4, registered) and instance B (32-bit, depth 8, fall-through).
module tb_hs_fifo_slice;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_full, a_empty;
    logic [7:0]  a_s_data, a_m_data;
    logic [2:0]  a_count;
    logic        b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_full, b_empty;
    logic [31:0] b_s_data, b_m_data;
    logic [3:0]  b_count;

    int tests = 0;
    int fails = 0;
    logic [7:0]  qa[$];
    logic [31:0] qb[$];
    int          ma_cnt = 0;
    int          mb_cnt = 0;
    logic        a_hold = 1'b0;
    logic [7:0]  a_hold_d = 8'h00;
    logic        b_pending = 1'b0;
    logic [31:0] b_pd = 32'h0;

    hs_fifo_slice #(.DATA_W(8), .DEPTH(4), .FALL_THROUGH(1'b0)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .s_valid(a_s_valid), .s_data(a_s_data), .s_ready(a_s_ready),
        .m_valid(a_m_valid), .m_data(a_m_data), .m_ready(a_m_ready),
        .count(a_count), .full(a_full), .empty(a_empty)
    );

    hs_fifo_slice #(.DATA_W(32), .DEPTH(8), .FALL_THROUGH(1'b1)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .s_valid(b_s_valid), .s_data(b_s_data), .s_ready(b_s_ready),
        .m_valid(b_m_valid), .m_data(b_m_data), .m_ready(b_m_ready),
        .count(b_count), .full(b_full), .empty(b_empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model and monitor for instance A, sampled on the falling edge.
    always @(negedge clk) begin : model_a
        logic exp_sr, exp_mv;
        int   exp_cnt;
        exp_cnt = rst ? 0 : ma_cnt;
        exp_sr  = !rst && !a_flush && (exp_cnt != 4);
        exp_mv  = !rst && !a_flush && (exp_cnt != 0);
        check("a_count", 32'(a_count), 32'(exp_cnt));
        check("a_full", 32'(a_full), 32'(exp_cnt == 4));
        check("a_empty", 32'(a_empty), 32'(exp_cnt == 0));
        check("a_s_ready", 32'(a_s_ready), 32'(exp_sr));
        check("a_m_valid", 32'(a_m_valid), 32'(exp_mv));
        if (a_hold && !rst && !a_flush) begin
            check("a_hold_valid", 32'(a_m_valid), 32'd1);
            check("a_hold_data", 32'(a_m_data), 32'(a_hold_d));
        end
        a_hold   <= a_m_valid && !a_m_ready;
        a_hold_d <= a_m_data;
        if (rst || a_flush) begin
            qa.delete();
            ma_cnt <= 0;
        end else begin
            if (a_s_valid && exp_sr) qa.push_back(a_s_data);
            if (exp_mv && a_m_ready) begin
                if (qa.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL a_sb_underflow: got %0h expected nothing", a_m_data);
                end else begin
                    check("a_sb_data", 32'(a_m_data), 32'(qa.pop_front()));
                end
            end
            ma_cnt <= exp_cnt + int'(a_s_valid && exp_sr) - int'(exp_mv && a_m_ready);
        end
    end

    // Reference model and monitor for instance B, plus the producer hold obligation.
    always @(negedge clk) begin : model_b
        logic exp_sr, exp_mv;
        int   exp_cnt;
        exp_cnt = rst ? 0 : mb_cnt;
        exp_sr  = !rst && !b_flush && (exp_cnt != 8);
        exp_mv  = !rst && !b_flush && ((exp_cnt != 0) || b_s_valid);
        check("b_count", 32'(b_count), 32'(exp_cnt));
        check("b_full", 32'(b_full), 32'(exp_cnt == 8));
        check("b_empty", 32'(b_empty), 32'(exp_cnt == 0));
        check("b_s_ready", 32'(b_s_ready), 32'(exp_sr));
        check("b_m_valid", 32'(b_m_valid), 32'(exp_mv));
        if (b_pending) begin
            check("b_producer_valid", 32'(b_s_valid), 32'd1);
            check("b_producer_data", b_s_data, b_pd);
        end
        b_pending <= b_s_valid && !exp_sr;
        b_pd      <= b_s_data;
        if (rst || b_flush) begin
            qb.delete();
            mb_cnt <= 0;
        end else begin
            if (b_s_valid && exp_sr) qb.push_back(b_s_data);
            if (exp_mv && b_m_ready) begin
                if (qb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_sb_underflow: got %0h expected nothing", b_m_data);
                end else begin
                    check("b_sb_data", b_m_data, qb.pop_front());
                end
            end
            mb_cnt <= exp_cnt + int'(b_s_valid && exp_sr) - int'(exp_mv && b_m_ready);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] fill_w [4];
        fill_w = '{8'h6B, 8'h00, 8'hCC, 8'h11};
        rst = 1'b1;
        a_flush = 1'b0; a_s_valid = 1'b0; a_s_data = 8'h00; a_m_ready = 1'b0;
        b_flush = 1'b0; b_s_valid = 1'b0; b_s_data = 32'h0; b_m_ready = 1'b0;
        repeat (3) step();
        check("rst_s_ready", 32'(a_s_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_s_ready", 32'(a_s_ready), 32'd1);
        check("rel_m_valid", 32'(a_m_valid), 32'd0);
        check("rel_count", 32'(a_count), 32'd0);
        check("rel_empty", 32'(a_empty), 32'd1);

        // Fill to full, then hold a fifth word that must not be taken.
        for (int i = 0; i < 4; i++) begin
            a_s_valid = 1'b1; a_s_data = fill_w[i];
            step();
            check("fill_count", 32'(a_count), 32'(i + 1));
        end
        check("fill_full", 32'(a_full), 32'd1);
        check("fill_s_ready", 32'(a_s_ready), 32'd0);
        a_s_data = 8'h22;
        repeat (3) step();
        check("fifth_held_count", 32'(a_count), 32'd4);
        a_s_valid = 1'b0;

        a_m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(a_m_valid), 32'd1);
            check("drain_data", 32'(a_m_data), 32'(fill_w[i]));
            step();
        end
        check("drain_empty", 32'(a_empty), 32'd1);
        check("drain_m_valid", 32'(a_m_valid), 32'd0);

        // Streaming through the registered instance: one cycle of latency.
        a_s_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_s_data = 8'(8'h30 + i);
            #1;
            if (i == 0) begin
                check("strA_first_valid", 32'(a_m_valid), 32'd0);
            end else begin
                check("strA_data", 32'(a_m_data), 32'(8'h30 + i - 1));
                check("strA_count", 32'(a_count), 32'd1);
            end
            step();
        end
        a_s_valid = 1'b0;
        step();
        a_m_ready = 1'b0;
        check("strA_empty", 32'(a_empty), 32'd1);

        // Reset mid-stream with three words stored.
        a_s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_s_data = 8'(i + 1);
            step();
        end
        a_s_valid = 1'b0;
        check("pre_rst_count", 32'(a_count), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_m_valid", 32'(a_m_valid), 32'd0);
        check("mid_rst_count", 32'(a_count), 32'd0);
        step();
        rst = 1'b0;
        a_s_valid = 1'b1; a_s_data = 8'h5A;
        step();
        a_s_valid = 1'b0;
        check("post_rst_valid", 32'(a_m_valid), 32'd1);
        check("post_rst_data", 32'(a_m_data), 32'h5A);
        a_m_ready = 1'b1;
        step();
        a_m_ready = 1'b0;

        // Flush with three stored words and simultaneous write/read attempts.
        a_s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_s_data = 8'(8'h10 * (i + 1));
            step();
        end
        check("pre_flush_count", 32'(a_count), 32'd3);
        a_flush = 1'b1; a_s_data = 8'h40; a_m_ready = 1'b1;
        #1;
        check("flush_s_ready", 32'(a_s_ready), 32'd0);
        check("flush_m_valid", 32'(a_m_valid), 32'd0);
        step();
        a_flush = 1'b0; a_s_valid = 1'b0; a_m_ready = 1'b0;
        check("post_flush_count", 32'(a_count), 32'd0);
        check("post_flush_empty", 32'(a_empty), 32'd1);
        a_s_valid = 1'b1; a_s_data = 8'hA5;
        step();
        a_s_valid = 1'b0;
        check("after_flush_data", 32'(a_m_data), 32'hA5);
        a_m_ready = 1'b1;
        step();
        a_m_ready = 1'b0;
        check("after_flush_empty", 32'(a_empty), 32'd1);

        // Fall-through instance: zero latency, storage stays empty.
        b_s_valid = 1'b1; b_m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b_s_data = 32'h1000 + 32'(i);
            #1;
            check("strB_valid", 32'(b_m_valid), 32'd1);
            check("strB_data", b_m_data, 32'h1000 + 32'(i));
            check("strB_count", 32'(b_count), 32'd0);
            step();
        end
        b_s_valid = 1'b0; b_m_ready = 1'b0;
        step();

        // Randomised traffic across pointer wrap; the producer holds stalled words.
        for (int i = 0; i < 1000; i++) begin
            if (!b_pending) begin
                b_s_valid = ($urandom_range(0, 3) != 0);
                b_s_data  = $urandom;
            end
            b_m_ready = ($urandom_range(0, 1) == 1);
            step();
        end
        b_s_valid = 1'b0; b_m_ready = 1'b1;
        repeat (12) step();
        b_m_ready = 1'b0;
        check("rand_final_count", 32'(b_count), 32'd0);
        check("rand_sb_left", 32'(qb.size()), 32'd0);
        check("a_sb_left", 32'(qa.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
